alu_arbiter: RTL and testbench

- Shares one combinational ALU (4-bit operation, two 32-bit operands, 32-bit result, zero flag) between NUM_REQ requesters, e.g. the integer pipeline and a branch/address unit.
- Each requester presents an operation over a valid/ready handshake.
- The arbiter grants requesters round-robin, drives the ALU from registered operands, captures the result, and returns it to the granted requester over a second valid/ready handshake.
- One operation is in flight at a time.

---
 rtl/alu_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and the arbiter state encoding.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage : alu_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping around, as both a one-hot grant and an index.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_rr_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IW-1:0]      o_grant_idx,
   output logic               o_any
);

   always_comb begin
      int unsigned v_idx;
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         v_idx = (32'(i_rr_ptr) + k) % NUM_REQ;
         if (!o_any && i_req[v_idx]) begin
            o_any          = 1'b1;
            o_grant[v_idx] = 1'b1;
            o_grant_idx    = IW'(v_idx);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters:
// round-robin accept, one registered operation in flight, held response.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [4*NUM_REQ-1:0]     req_op,
   input  logic [WIDTH*NUM_REQ-1:0] req_a,
   input  logic [WIDTH*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]         resp_result,
   output logic                     resp_zero,
   output logic [3:0]               alu_op,
   output logic [WIDTH-1:0]         alu_operand1,
   output logic [WIDTH-1:0]         alu_operand2,
   input  logic [WIDTH-1:0]         alu_result,
   input  logic                     alu_zero
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t         r_state, w_state_nxt;
   logic [IW-1:0]      r_rr_ptr, r_grant_idx, w_grant_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_any, w_accept, w_resp_done;
   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_a, r_b, r_result;
   logic               r_zero;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr (
      .i_req       (req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any       (w_any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      resp_valid  = '0;
      w_accept    = 1'b0;
      w_resp_done = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = w_grant;
            if (w_any) begin
               w_accept    = 1'b1;
               w_state_nxt = EXEC;
            end
         end
         EXEC: w_state_nxt = RESP;
         RESP: begin
            resp_valid[r_grant_idx] = 1'b1;
            if (resp_ready[r_grant_idx]) begin
               w_resp_done = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand registers load only on acceptance so the ALU inputs stay quiet otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_result    <= '0;
         r_zero      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_grant_idx <= w_grant_idx;
            r_op        <= req_op[w_grant_idx*4 +: 4];
            r_a         <= req_a[w_grant_idx*WIDTH +: WIDTH];
            r_b         <= req_b[w_grant_idx*WIDTH +: WIDTH];
         end
         if (r_state == EXEC) begin
            r_result <= alu_result;
            r_zero   <= alu_zero;
         end
         if (w_resp_done)
            r_rr_ptr <= (r_grant_idx == IW'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;
      end
   end

   assign alu_op       = r_op;
   assign alu_operand1 = r_a;
   assign alu_operand2 = r_b;
   assign resp_result  = r_result;
   assign resp_zero    = r_zero;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NR = 2;
   localparam int W  = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid, req_ready, resp_valid, resp_ready;
   logic [4*NR-1:0] req_op;
   logic [W*NR-1:0] req_a, req_b;
   logic [W-1:0]    resp_result, alu_operand1, alu_operand2, alu_result;
   logic            resp_zero, alu_zero;
   logic [3:0]      alu_op;

   int n_checks = 0;
   int n_fail   = 0;

   alu_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_result  (resp_result),
      .resp_zero    (resp_zero),
      .alu_op       (alu_op),
      .alu_operand1 (alu_operand1),
      .alu_operand2 (alu_operand2),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero)
   );

   always #5 clk = ~clk;

   // Reference ALU: zero flag only on SUB with equal operands, unknown ops give 0.
   always_comb begin
      alu_result = '0;
      alu_zero   = 1'b0;
      case (alu_op)
         ALU_ADD: alu_result = alu_operand1 + alu_operand2;
         ALU_OR:  alu_result = alu_operand1 | alu_operand2;
         ALU_AND: alu_result = alu_operand1 & alu_operand2;
         ALU_SUB: begin
            alu_result = alu_operand1 - alu_operand2;
            alu_zero   = (alu_operand1 == alu_operand2);
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[4*r +: 4] = op;
      req_a[W*r +: W]  = a;
      req_b[W*r +: W]  = b;
   endtask

   task automatic do_op(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_z, input int hold);
      logic [NR-1:0] oh;
      oh = '0;
      oh[r] = 1'b1;
      set_req(r, op, a, b);
      req_valid[r] = 1'b1;
      #1 check("accept_ready", req_ready, oh);
      tick();
      req_valid[r] = 1'b0;
      if (hold > 0) resp_ready = ~oh;
      #1;
      check("exec_ready", req_ready, '0);
      check("exec_resp_valid", resp_valid, '0);
      check("exec_alu_op", alu_op, op);
      check("exec_alu_a", alu_operand1, a);
      check("exec_alu_b", alu_operand2, b);
      tick();
      #1;
      check("resp_valid", resp_valid, oh);
      check("resp_result", resp_result, exp_res);
      check("resp_zero", resp_zero, exp_z);
      for (int h = 0; h < hold; h++) begin
         req_valid = ~oh;
         tick();
         #1;
         check("hold_valid", resp_valid, oh);
         check("hold_result", resp_result, exp_res);
         check("hold_zero", resp_zero, exp_z);
         check("hold_no_grant", req_ready, '0);
      end
      req_valid  = '0;
      resp_ready = '1;
      tick();
      #1 check("resp_done", resp_valid, '0);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = '1;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      repeat (3) tick();
      check("rst_req_ready", req_ready, '0);
      check("rst_resp_valid", resp_valid, '0);
      check("rst_result", resp_result, '0);
      check("rst_zero", resp_zero, '0);
      check("rst_alu_op", alu_op, '0);
      check("rst_alu_a", alu_operand1, '0);
      check("rst_alu_b", alu_operand2, '0);
      rst_n = 1'b1;
      tick();

      // 1: single ADD
      do_op(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 0);
      // 2: SUB equal with backpressure, requester 0 waiting meanwhile
      do_op(1, ALU_SUB, 32'h1234, 32'h1234, 32'd0, 1'b1, 3);

      // 3: fairness with both requesters continuously valid, pointer at 0
      set_req(0, ALU_OR, 32'hF0, 32'h0F);
      set_req(1, ALU_AND, 32'hFF, 32'h0F);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1 check("rr_ready", req_ready, (k % 2 == 0) ? 64'd1 : 64'd2);
         tick();
         tick();
         #1;
         check("rr_resp_valid", resp_valid, (k % 2 == 0) ? 64'd1 : 64'd2);
         check("rr_result", resp_result, (k % 2 == 0) ? 64'hFF : 64'h0F);
         tick();
      end
      req_valid = '0;
      tick();

      // 4: unsupported opcode
      do_op(0, 4'b1111, 32'd9, 32'd9, 32'd0, 1'b0, 0);

      // 5: reset during EXEC (pointer is 1 before the reset)
      set_req(1, ALU_ADD, 32'd3, 32'd4);
      req_valid = 2'b10;
      #1 check("r5_accept", req_ready, 2'b10);
      tick();
      req_valid = '0;
      #1 check("r5_exec_alu_a", alu_operand1, 32'd3);
      rst_n = 1'b0;
      tick();
      #1;
      check("r5_alu_op", alu_op, '0);
      check("r5_alu_a", alu_operand1, '0);
      check("r5_alu_b", alu_operand2, '0);
      check("r5_resp_valid", resp_valid, '0);
      check("r5_result", resp_result, '0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         #1 check("r5_no_resp", resp_valid, '0);
      end

      // 6: wrap-around; both valid proves the pointer returned to 0
      set_req(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
      set_req(1, ALU_OR, 32'd1, 32'd2);
      req_valid = 2'b11;
      #1 check("w6_ptr_reset_grant", req_ready, 2'b01);
      tick();
      req_valid = '0;
      tick();
      #1;
      check("w6_add_valid", resp_valid, 2'b01);
      check("w6_add_result", resp_result, 32'd0);
      check("w6_add_zero", resp_zero, 1'b0);
      tick();
      do_op(0, ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule : tb_alu_arbiter
